// File: rtl/modred_pkg.sv
// Shared types and defaults for the special-modulus reducer and its operand multiplier.
package modred_pkg;

  localparam int unsigned OPERAND_WIDTH = 32;
  localparam int unsigned DATA_LENGTH   = 2 * OPERAND_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } opmul_state_t;

  // Width of the iteration counter for a given operand width.
  function automatic int unsigned opmul_cnt_width(int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/modred_operand_mul_if.sv
// Request/response bundle between the operand multiplier and its driver.
interface modred_operand_mul_if #(
  parameter int unsigned OPERAND_WIDTH = modred_pkg::OPERAND_WIDTH,
  parameter int unsigned DATA_LENGTH   = 2 * OPERAND_WIDTH
) ();

  logic                     start_i;
  logic [OPERAND_WIDTH-1:0] a_i;
  logic [OPERAND_WIDTH-1:0] b_i;
  logic [DATA_LENGTH-1:0]   m_i;
  logic                     ready_i;
  logic                     busy_o;
  logic                     valid_o;
  logic [DATA_LENGTH-1:0]   x_o;
  logic [DATA_LENGTH-1:0]   m_o;
  logic [DATA_LENGTH-1:0]   m_bl_o;

  modport master (
    output start_i, a_i, b_i, m_i, ready_i,
    input  busy_o, valid_o, x_o, m_o, m_bl_o
  );

  modport slave (
    input  start_i, a_i, b_i, m_i, ready_i,
    output busy_o, valid_o, x_o, m_o, m_bl_o
  );

endinterface

// File: rtl/modred_bitlen.sv
// Bit length of a value: index of the highest set bit plus one, zero for zero.
module modred_bitlen #(
  parameter int unsigned DATA_LENGTH = modred_pkg::DATA_LENGTH
) (
  input  logic [DATA_LENGTH-1:0] i_value,
  output logic [DATA_LENGTH-1:0] o_bit_length
);

  // Ascending scan, so the highest set bit is the last one to write.
  always_comb begin
    o_bit_length = '0;
    for (int unsigned i = 0; i < DATA_LENGTH; i++) begin
      if (i_value[i]) begin
        o_bit_length = DATA_LENGTH'(i + 1);
      end
    end
  end

endmodule

// File: rtl/modred_operand_mul.sv
// Iterative shift-add multiplier feeding {product, modulus, bit length} to the reducer.
// Define OPMUL_RADIX4_EN to retire two multiplier bits per cycle instead of one.
module modred_operand_mul
  import modred_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH = modred_pkg::OPERAND_WIDTH,
  parameter int unsigned DATA_LENGTH   = 2 * OPERAND_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  modred_operand_mul_if.slave io_bus
);

  localparam int unsigned CNT_W = opmul_cnt_width(OPERAND_WIDTH);
`ifdef OPMUL_RADIX4_EN
  localparam int unsigned STEP  = 2;
`else
  localparam int unsigned STEP  = 1;
`endif
  localparam int unsigned ITERS = OPERAND_WIDTH / STEP;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  if (DATA_LENGTH != 2 * OPERAND_WIDTH) begin : g_bad_data_length
    $error("DATA_LENGTH must equal 2*OPERAND_WIDTH");
  end
`ifdef OPMUL_RADIX4_EN
  if (OPERAND_WIDTH % 2 != 0) begin : g_odd_operand_width
    $error("OPERAND_WIDTH must be even for radix-4 operation");
  end
`endif

  opmul_state_t             r_state;
  logic [DATA_LENGTH-1:0]   r_a_sh;
  logic [OPERAND_WIDTH-1:0] r_b_sh;
  logic [DATA_LENGTH-1:0]   r_acc;
  logic [DATA_LENGTH-1:0]   r_x;
  logic [DATA_LENGTH-1:0]   r_m;
  logic [DATA_LENGTH-1:0]   r_m_bl;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_busy;
  logic                     r_valid;
`ifdef OPMUL_RADIX4_EN
  logic [DATA_LENGTH-1:0]   r_a3_sh;
`endif

  logic [DATA_LENGTH-1:0]   w_a_ext;
  logic [DATA_LENGTH-1:0]   w_m_bl;
  logic [DATA_LENGTH-1:0]   w_pp;
  logic [DATA_LENGTH-1:0]   w_acc_next;

  assign w_a_ext = DATA_LENGTH'(io_bus.a_i);

  modred_bitlen #(
    .DATA_LENGTH (DATA_LENGTH)
  ) u_bitlen (
    .i_value      (io_bus.m_i),
    .o_bit_length (w_m_bl)
  );

  // r_a_sh already carries a << cnt, so each partial product is a plain select.
  always_comb begin
    w_pp = '0;
`ifdef OPMUL_RADIX4_EN
    unique case (r_b_sh[1:0])
      2'b00:   w_pp = '0;
      2'b01:   w_pp = r_a_sh;
      2'b10:   w_pp = r_a_sh << 1;
      default: w_pp = r_a3_sh;
    endcase
`else
    if (r_b_sh[0]) begin
      w_pp = r_a_sh;
    end
`endif
    w_acc_next = r_acc + w_pp;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_x     <= '0;
      r_m     <= '0;
      r_m_bl  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
`ifdef OPMUL_RADIX4_EN
      r_a3_sh <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (io_bus.start_i) begin
            r_a_sh  <= w_a_ext;
            r_b_sh  <= io_bus.b_i;
            r_m     <= io_bus.m_i;
            r_m_bl  <= w_m_bl;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= MUL;
`ifdef OPMUL_RADIX4_EN
            r_a3_sh <= w_a_ext + (w_a_ext << 1);
`endif
          end
        end
        MUL: begin
          r_acc  <= w_acc_next;
          r_a_sh <= r_a_sh << STEP;
          r_b_sh <= r_b_sh >> STEP;
          r_cnt  <= r_cnt + CNT_W'(1);
`ifdef OPMUL_RADIX4_EN
          r_a3_sh <= r_a3_sh << STEP;
`endif
          if (r_cnt == LAST_ITER) begin
            r_x     <= w_acc_next;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (io_bus.ready_i) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.busy_o  = r_busy;
  assign io_bus.valid_o = r_valid;
  assign io_bus.x_o     = r_x;
  assign io_bus.m_o     = r_m;
  assign io_bus.m_bl_o  = r_m_bl;

endmodule

// File: tb/tb_modred_operand_mul.sv
// Scoreboard bench for modred_operand_mul: directed cases, reset mid-run, random traffic.
module tb_modred_operand_mul;

  localparam int unsigned OW = 32;
  localparam int unsigned DL = 64;
`ifdef OPMUL_RADIX4_EN
  localparam int unsigned LAT = OW / 2;
`else
  localparam int unsigned LAT = OW;
`endif

  typedef struct packed {
    logic [DL-1:0] x;
    logic [DL-1:0] m;
    logic [DL-1:0] m_bl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  modred_operand_mul_if #(.OPERAND_WIDTH(OW), .DATA_LENGTH(DL)) bus ();

  modred_operand_mul #(
    .OPERAND_WIDTH (OW),
    .DATA_LENGTH   (DL)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io_bus (bus)
  );

  task automatic check_eq(input string tag, input logic [DL-1:0] got, input logic [DL-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                 input logic [DL-1:0] m);
    exp_t r;
    logic [DL:0] mp1;
    mp1    = {1'b0, m} + (DL+1)'(1);
    r.x    = DL'(a) * DL'(b);
    r.m    = m;
    r.m_bl = DL'($clog2(mp1));
    return r;
  endfunction

  // Results are retired at the negedge preceding the handshake edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.valid_o && bus.ready_i) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", DL'(sb.size()), DL'(1));
      end else begin
        e = sb.pop_front();
        check_eq("x_o", bus.x_o, e.x);
        check_eq("m_o", bus.m_o, e.m);
        check_eq("m_bl_o", bus.m_bl_o, e.m_bl);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, DL'(bus.valid_o), '0);
    check_eq({tag, "_busy"}, DL'(bus.busy_o), '0);
    check_eq({tag, "_x"}, bus.x_o, '0);
    check_eq({tag, "_m"}, bus.m_o, '0);
    check_eq({tag, "_m_bl"}, bus.m_bl_o, '0);
  endtask

  // One request; inputs change 2 time units after each posedge.
  task automatic do_txn(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic [DL-1:0] m,
                        input int hold, input bit rand_ready, input bit inject);
    exp_t e;
    int   n;
    bit   got;
    e = model(a, b, m);
    n = 0;
    while (bus.busy_o && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("idle_before_start", DL'(bus.busy_o), '0);
    bus.start_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.m_i     = m;
    bus.ready_i = 1'b0;
    sb.push_back(e);
    @(posedge clk); #2;
    bus.start_i = 1'b0;
    check_eq("busy_on_accept", DL'(bus.busy_o), DL'(1));
    n   = 0;
    got = 1'b0;
    while (!got && n < int'(LAT) + 8) begin
      @(posedge clk); #2;
      n++;
      if (bus.valid_o) begin
        got = 1'b1;
      end else begin
        bus.ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        if (inject) begin
          bus.start_i = (n == 5);
          bus.a_i     = 5;
          bus.b_i     = 7;
          if (n == 7) check_eq("busy_after_drop", DL'(bus.busy_o), DL'(1));
        end
      end
    end
    bus.start_i = 1'b0;
    check_eq("latency", DL'(n), DL'(LAT));
    bus.ready_i = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      check_eq("bp_valid", DL'(bus.valid_o), DL'(1));
      check_eq("bp_x", bus.x_o, e.x);
      check_eq("bp_m_bl", bus.m_bl_o, e.m_bl);
    end
    bus.ready_i = 1'b1;
    @(posedge clk); #2;
    bus.ready_i = 1'b0;
    check_eq("valid_after_hs", DL'(bus.valid_o), '0);
    check_eq("busy_after_hs", DL'(bus.busy_o), '0);
    check_eq("x_held_after_hs", bus.x_o, e.x);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DL-1:0] rm;
    bus.start_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.m_i     = '0;
    bus.ready_i = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    do_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1_0000_0001, 2, 1'b0, 1'b0);
    check_eq("t1_x", bus.x_o, 64'hFFFF_FFFE_0000_0001);
    check_eq("t1_m_bl", bus.m_bl_o, 64'd33);

    do_txn(32'h0, 32'h1234_5678, 64'h7FFF_FFFF, 0, 1'b0, 1'b0);
    check_eq("t2_x", bus.x_o, '0);
    check_eq("t2_m_bl", bus.m_bl_o, 64'd31);

    do_txn(32'hDEAD_BEEF, 32'h0123_4567, 64'hFFFF_FFFF_FFFF_FFFF, 10, 1'b0, 1'b0);

    do_txn(32'd3, 32'd4, 64'hF, 0, 1'b0, 1'b1);
    check_eq("t4_x", bus.x_o, 64'd12);
    repeat (3) @(posedge clk);
    #2;
    check_eq("t4_no_second_valid", DL'(bus.valid_o), '0);
    check_eq("t4_idle", DL'(bus.busy_o), '0);

    bus.start_i = 1'b1;
    bus.a_i     = 32'd9;
    bus.b_i     = 32'd9;
    bus.m_i     = 64'h55;
    @(posedge clk); #2;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    check_reset_outputs("mid_mul_reset");
    @(posedge clk); #2;
    check_eq("post_reset_idle", DL'(bus.valid_o), '0);
    do_txn(32'd6, 32'd7, 64'h0, 1, 1'b0, 1'b0);
    check_eq("t5_x", bus.x_o, 64'd42);
    check_eq("t5_m_bl", bus.m_bl_o, '0);

    for (int t = 0; t < 1000; t++) begin
      rm = {$urandom, $urandom};
      rm = rm >> $urandom_range(0, 63);
      do_txn($urandom, $urandom, rm, $urandom_range(0, 2), 1'b1, 1'b0);
    end

    check_eq("sb_drained", DL'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
